// File: rtl/xfmr_layer_scheduler.sv
// rtl/xfmr_layer_scheduler.sv - token buffer and layer sequencer for one shared transformer block
// Loads a batch, runs every token through every layer in place, then drains the result.
module xfmr_layer_scheduler #(
  parameter int D          = 2,
  parameter int DW         = 8,
  parameter int SEQ_LEN    = 2,
  parameter int NUM_LAYERS = 4,
  parameter int TIMEOUT    = 1024,
  parameter int TW         = ($clog2(SEQ_LEN) > 0) ? $clog2(SEQ_LEN) : 1,
  parameter int LW         = ($clog2(NUM_LAYERS) > 0) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:D-1][DW-1:0] in_x,
  output logic                 blk_start,
  output logic [0:D-1][DW-1:0] blk_x,
  output logic [LW-1:0]        layer_idx,
  input  logic                 blk_valid,
  input  logic [0:D-1][DW-1:0] blk_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:D-1][DW-1:0] out_y,
  output logic [TW-1:0]        out_tok,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST_TOK   = TW'(SEQ_LEN - 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [CW-1:0] TMR_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DRAIN} state_t;
  typedef logic [0:D-1][DW-1:0] tok_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tok_q, tok_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          timeout_err_q, timeout_err_d;

  tok_t tok_buf_q [SEQ_LEN];
  logic buf_we;
  tok_t buf_wd;

  always_comb begin
    state_d       = state_q;
    tok_d         = tok_q;
    layer_d       = layer_q;
    tmr_d         = tmr_q;
    timeout_err_d = timeout_err_q;
    buf_we        = 1'b0;
    buf_wd        = in_x;
    in_ready      = 1'b0;
    blk_start     = 1'b0;
    out_valid     = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD;
          tok_d         = '0;
          layer_d       = '0;
          timeout_err_d = 1'b0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we = 1'b1;
          buf_wd = in_x;
          if (tok_q == LAST_TOK) begin
            tok_d   = '0;
            state_d = S_ISSUE;
          end else begin
            tok_d = tok_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        blk_start = 1'b1;
        tmr_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        tmr_d = tmr_q + 1'b1;
        // A result landing on the last timer cycle still counts as on time.
        if (blk_valid) begin
          buf_we = 1'b1;
          buf_wd = blk_y;
          if (tok_q != LAST_TOK) begin
            tok_d   = tok_q + 1'b1;
            state_d = S_ISSUE;
          end else if (layer_q != LAST_LAYER) begin
            tok_d   = '0;
            layer_d = layer_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            tok_d   = '0;
            state_d = S_DRAIN;
          end
        end else if (tmr_q == TMR_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (tok_q == LAST_TOK) begin
            done    = 1'b1;
            tok_d   = '0;
            state_d = S_IDLE;
          end else begin
            tok_d = tok_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tok_q         <= '0;
      layer_q       <= '0;
      tmr_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tok_q         <= tok_d;
      layer_q       <= layer_d;
      tmr_q         <= tmr_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Token storage carries no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) tok_buf_q[tok_q] <= buf_wd;
  end

  assign blk_x       = tok_buf_q[tok_q];
  assign out_y       = tok_buf_q[tok_q];
  assign out_tok     = tok_q;
  assign layer_idx   = layer_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;

endmodule
